// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display path: blanking constants,
// scan FSM states, the display buffer record and the hex-to-segment decode.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } disp_buf_t;

  // Cleared buffer: zero data, no decimal points, every digit dark.
  localparam disp_buf_t BUF_RESET = '{data: 16'h0000, dp: 4'h0, blank: 4'hF};

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] pattern;
    case (nibble)
      4'h0: pattern = 7'h40;
      4'h1: pattern = 7'h79;
      4'h2: pattern = 7'h24;
      4'h3: pattern = 7'h30;
      4'h4: pattern = 7'h19;
      4'h5: pattern = 7'h12;
      4'h6: pattern = 7'h02;
      4'h7: pattern = 7'h78;
      4'h8: pattern = 7'h00;
      4'h9: pattern = 7'h10;
      4'hA: pattern = 7'h08;
      4'hB: pattern = 7'h03;
      4'hC: pattern = 7'h46;
      4'hD: pattern = 7'h21;
      4'hE: pattern = 7'h06;
      default: pattern = 7'h0E;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low segment decoder, shared with the adder top.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit common-anode display driver with per-slot blanking guard
// and a double-buffered digit store that only swaps at frame boundaries.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] digit_data,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  scan_state_e   state_q, state_d;
  disp_buf_t     active_q, active_d;
  disp_buf_t     pend_q, pend_d;
  logic          pending_q, pending_d;
  logic          wrap, boundary;

  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          frame_done_q, frame_done_d;

  logic [3:0]    nibble;
  logic [6:0]    dec_seg;

  // Slot counter wraps every REFRESH_DIV cycles and steps the digit index.
  always_comb begin
    wrap     = (cnt_q == CNT_MAX);
    boundary = wrap && (idx_q == 2'd3);
    cnt_d    = wrap ? '0 : cnt_q + CW'(1);
    idx_d    = wrap ? idx_q + 2'd1 : idx_q;
  end

  // Scan position and FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      state_q <= BLANK;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  // Guard period ends when the counter reaches GUARD_CYCLES; every slot wrap re-arms it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK:   if (cnt_d >= CNT_GUARD) state_d = DRIVE;
      DRIVE:   if (wrap && (CNT_GUARD != '0)) state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  // Commit pending data at the frame boundary first, then let a same-cycle load refill it.
  always_comb begin
    active_d  = active_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    if (boundary && pending_q) begin
      active_d  = pend_q;
      pending_d = 1'b0;
    end
    if (load) begin
      pend_d    = '{data: digit_data, dp: dp_in, blank: blank_in};
      pending_d = 1'b1;
    end
  end

  // Active and pending buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= BUF_RESET;
      pend_q    <= BUF_RESET;
      pending_q <= 1'b0;
    end else begin
      active_q  <= active_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
    end
  end

  assign nibble = 4'(active_d.data >> {idx_d, 2'b00});

  seg7_hex_decode u_decode (
    .nibble_i (nibble),
    .seg_o    (dec_seg)
  );

  // Outputs are computed from next-state so the registered pins line up with the counter.
  always_comb begin
    an_d         = AN_OFF;
    seg_d        = SEG_OFF;
    dp_d         = 1'b1;
    frame_done_d = (cnt_d == CNT_MAX) && (idx_d == 2'd3);
    if (state_d == DRIVE) begin
      an_d = ~(4'b0001 << idx_d);
      if (!active_d.blank[idx_d]) begin
        seg_d = dec_seg;
        dp_d  = ~active_d.dp[idx_d];
      end
    end
  end

  // Registered display pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with an 8-cycle slot and 2-cycle guard.
module tb_seg7_scan_driver;

  localparam int RD    = 8;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * RD;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] digit_data;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        pending;
  logic        frame_done;

  seg7_scan_driver #(
    .REFRESH_DIV  (RD),
    .GUARD_CYCLES (GUARD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .digit_data (digit_data),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .pending    (pending),
    .frame_done (frame_done)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the stimulus never finishes.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [6:0] segTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: cycle count since reset plus what the display holds and what waits.
  int          t;
  logic [15:0] mData, pData;
  logic [3:0]  mDp, pDp, mBlank, pBlank;
  logic        mPending;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dpv;
    logic [3:0]  blk;
    int          dig;
    logic [3:0]  expAn;
    logic [6:0]  expSeg;
    logic        expDp;
  } vec_t;

  vec_t vecs [10];

  function automatic void resetModel();
    t        = 0;
    mData    = 16'h0000;
    mDp      = 4'h0;
    mBlank   = 4'hF;
    pData    = 16'h0000;
    pDp      = 4'h0;
    pBlank   = 4'hF;
    mPending = 1'b0;
  endfunction

  function automatic logic [13:0] modelOut();
    int         pos  = t % RD;
    int         dig  = (t / RD) % 4;
    logic [3:0] eAn  = 4'hF;
    logic [6:0] eSeg = 7'h7F;
    logic       eDp  = 1'b1;
    logic [3:0] nib;
    if (pos >= GUARD) begin
      eAn[dig] = 1'b0;
      if (!mBlank[dig]) begin
        nib  = 4'((mData >> (4 * dig)) & 16'h000F);
        eSeg = segTable[nib];
        eDp  = !mDp[dig];
      end
    end
    return {eAn, eSeg, eDp, mPending, (t % FRAME) == FRAME - 1};
  endfunction

  task automatic checkOutput(input string name, input logic [13:0] act, input logic [13:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0d)", name, act, expv, t);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare on the falling edge.
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    bit bnd;
    load       = ld;
    digit_data = d;
    dp_in      = p;
    blank_in   = b;
    bnd = ((t % FRAME) == FRAME - 1);
    @(posedge clk);
    if (bnd && mPending) begin
      mData    = pData;
      mDp      = pDp;
      mBlank   = pBlank;
      mPending = 1'b0;
    end
    if (ld) begin
      pData    = d;
      pDp      = p;
      pBlank   = b;
      mPending = 1'b1;
    end
    t++;
    @(negedge clk);
    checkOutput("scan", {an, seg, dp, pending, frame_done}, modelOut());
    load = 1'b0;
  endtask

  task automatic runTo(input int target);
    while (t < target) step(1'b0, 16'h0000, 4'h0, 4'h0);
  endtask

  // Load one table record, wait for its frame and digit slot, compare the pins.
  task automatic applyStimulus(input vec_t v);
    int tl = t;
    int fs;
    step(1'b1, v.data, v.dpv, v.blk);
    fs = ((tl + 1) / FRAME + 1) * FRAME;
    runTo(fs + v.dig * RD + GUARD + int'($urandom_range(0, RD - GUARD - 1)));
    checkOutput("table", {an, seg, dp, 2'b00}, {v.expAn, v.expSeg, v.expDp, 2'b00});
  endtask

  initial begin
    int fs;
    vecs[0] = '{16'h3210, 4'h0, 4'h0, 0, 4'hE, 7'h40, 1'b1};
    vecs[1] = '{16'h3210, 4'h0, 4'h0, 1, 4'hD, 7'h79, 1'b1};
    vecs[2] = '{16'h3210, 4'h0, 4'h0, 2, 4'hB, 7'h24, 1'b1};
    vecs[3] = '{16'h3210, 4'h0, 4'h0, 3, 4'h7, 7'h30, 1'b1};
    vecs[4] = '{16'hFEDC, 4'h1, 4'h8, 0, 4'hE, 7'h46, 1'b0};
    vecs[5] = '{16'hFEDC, 4'h1, 4'h8, 1, 4'hD, 7'h21, 1'b1};
    vecs[6] = '{16'hFEDC, 4'h1, 4'h8, 2, 4'hB, 7'h06, 1'b1};
    vecs[7] = '{16'hFEDC, 4'h1, 4'h8, 3, 4'h7, 7'h7F, 1'b1};
    vecs[8] = '{16'h9876, 4'hA, 4'h0, 1, 4'hD, 7'h78, 1'b0};
    vecs[9] = '{16'h9876, 4'hA, 4'h0, 3, 4'h7, 7'h10, 1'b0};

    rst_n      = 1'b0;
    load       = 1'b0;
    digit_data = 16'h0000;
    dp_in      = 4'h0;
    blank_in   = 4'h0;
    resetModel();
    repeat (3) @(negedge clk);
    checkOutput("reset", {an, seg, dp, pending, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    rst_n = 1'b1;
    resetModel();
    checkOutput("postRelease", {an, seg, dp, pending, frame_done}, modelOut());

    runTo(10);
    checkOutput("firstFrameDark", {an, seg, dp, 2'b00}, {4'hD, 7'h7F, 1'b1, 2'b00});
    runTo(40);

    step(1'b1, 16'h3210, 4'h0, 4'h0);
    checkOutput("pendingSet", {13'b0, pending}, 14'd1);
    runTo(63);
    checkOutput("frameDone", {12'b0, pending, frame_done}, 14'd3);
    runTo(64);
    checkOutput("pendingClear", {12'b0, pending, frame_done}, 14'd0);
    runTo(66);
    checkOutput("newFrameDigit0", {an, seg, dp, 2'b00}, {4'hE, 7'h40, 1'b1, 2'b00});

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    while ((t % FRAME) != 2) step(1'b0, 16'h0000, 4'h0, 4'h0);
    step(1'b1, 16'h1111, 4'h0, 4'h0);
    step(1'b0, 16'h0000, 4'h0, 4'h0);
    step(1'b0, 16'h0000, 4'h0, 4'h0);
    step(1'b1, 16'h2222, 4'h0, 4'h0);
    fs = t - (t % FRAME) + FRAME;
    for (int d = 0; d < 4; d++) begin
      runTo(fs + d * RD + 4);
      checkOutput("lastLoadWins", {7'b0, seg}, {7'b0, 7'h24});
    end

    while ((t % FRAME) != 3) step(1'b0, 16'h0000, 4'h0, 4'h0);
    step(1'b1, 16'h4444, 4'h0, 4'h0);
    while ((t % FRAME) != FRAME - 1) step(1'b0, 16'h0000, 4'h0, 4'h0);
    step(1'b1, 16'h3333, 4'h0, 4'h0);
    checkOutput("collisionPending", {13'b0, pending}, 14'd1);
    fs = t;
    runTo(fs + RD + 4);
    checkOutput("collisionOld", {an, seg, dp, 2'b00}, {4'hD, 7'h19, 1'b1, 2'b00});
    runTo(fs + FRAME + 2 * RD + 3);
    checkOutput("collisionNew", {an, seg, dp, 2'b00}, {4'hB, 7'h30, 1'b1, 2'b00});
    checkOutput("collisionCleared", {13'b0, pending}, 14'd0);

    while (!(((t % FRAME) >= RD + GUARD) && ((t % FRAME) < 2 * RD))) step(1'b0, 16'h0000, 4'h0, 4'h0);
    checkOutput("preResetAn", {10'b0, an}, {10'b0, 4'hD});
    rst_n = 1'b0;
    #1;
    checkOutput("asyncReset", {an, seg, dp, pending, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
    runTo(12);
    checkOutput("darkAfterReset", {an, seg, dp, 2'b00}, {4'hD, 7'h7F, 1'b1, 2'b00});
    runTo(40);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 11) == 0), 16'($urandom), 4'($urandom), 4'($urandom) & 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Display-side consumer of the adder result path: takes up to four hex digits and drives a multiplexed 4-digit common-anode seven-segment display (Basys3-style, active-low cathodes and anodes).
- Time-multiplexes the digits with a programmable refresh period and an anti-ghosting blanking guard per digit slot.
- Double-buffers loaded data so that a frame never tears.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range >= 4.
- GUARD_CYCLES, 16, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  one-cycle strobe; captures digit_data, dp_in and blank_in into the pending buffer.
- digit_data  input  16  four nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
- dp_in  input  4  decimal point per digit, 1 = lit.
- blank_in  input  4  per-digit blank, 1 = digit dark.
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal-point cathode, active-low.
- an  output  4  anodes, active-low; an[i] enables digit i.
- pending  output  1  high while loaded data is waiting for the next frame boundary.
- frame_done  output  1  one-cycle pulse at the end of digit 3's slot.

Behaviour:
- Interface: one clock domain (clk); reset rst_n is asynchronous and active-low.
- Reset values: seg = 7'h7F, dp = 1, an = 4'hF, pending = 0, frame_done = 0. Slot counter = 0, digit index = 0, FSM in BLANK. Active and pending buffers cleared to data 0, dp 0, blank 4'hF (display dark).
- All outputs are registered; no combinational path from inputs to outputs.
- Slot counter runs 0..REFRESH_DIV-1 and wraps. At wrap, digit index increments 0->1->2->3->0.
- FSM, two states per slot:
  - BLANK: counter < GUARD_CYCLES; an = 4'hF, seg = 7'h7F, dp = 1.
  - DRIVE: remaining cycles of the slot.
  - BLANK->DRIVE when the counter reaches GUARD_CYCLES. DRIVE->BLANK at counter wrap.
- DRIVE outputs for digit i:
  - an = ~(1<<i).
  - seg = decoded nibble i of the active buffer; dp = ~dp_active[i].
  - If blank_active[i] = 1: an[i] is still asserted, but seg = 7'h7F and dp = 1.
- Decode table (active-low {g..a}): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Frame boundary is the counter wrap out of digit 3.
  - frame_done pulses on that cycle.
  - If pending = 1, the pending buffer is copied to the active buffer on the same edge and pending clears. Digit 0 of the new frame shows the new data.
- load sets pending = 1 on the next edge and overwrites the pending buffer.
  - Multiple loads before a boundary: the last one wins.
  - load on the same cycle as a frame boundary: the current pending content commits first, then the newly loaded data becomes pending (pending stays 1).
- Update latency: new data is visible no earlier than the start of the next frame, and at most 4*REFRESH_DIV + GUARD_CYCLES + 1 cycles after load.
- Reset mid-frame: outputs go to reset values immediately (async). Both buffers clear, and scanning restarts at digit 0, BLANK, after rst_n deasserts.
- Scanning runs continuously. A load never stalls or resynchronises the scan.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16-entry active-low segment decode constant/function;
  - SEG_OFF = 7'h7F and AN_OFF = 4'hF;
  - an FSM state enum {BLANK, DRIVE}.
- One sub-module: seg7_hex_decode, a combinational nibble -> seg function, reused by the existing adder top.

Test Plan:
All scenarios use REFRESH_DIV = 8 and GUARD_CYCLES = 2, giving a 32-cycle frame.
- Reset: hold rst_n = 0, then release. -> an = F, seg = 7F, dp = 1. In the first frame, after the guard, an cycles E,D,B,7 with seg = 7F, since blank defaults to all 1.
- Basic scan: load digit_data = 16'h3210, dp_in = 0, blank_in = 0 mid-frame. -> pending = 1 until the frame boundary, frame_done pulses, pending clears. Next frame shows, per slot, 2 cycles with an = F, then 6 cycles of: an = E/seg = 40, an = D/seg = 79, an = B/seg = 24, an = 7/seg = 30.
- Hex and dp/blank: load 16'hFEDC, dp_in = 4'b0001, blank_in = 4'b1000. -> digit 0: seg = 46, dp = 0. Digit 1: 21. Digit 2: 06. Digit 3: an = 7 with seg = 7F, dp = 1.
- Last-load-wins and boundary collision:
  - Load 16'h1111, then 16'h2222 before the boundary. -> the next frame shows 24 on every digit.
  - Load 16'h3333 exactly on the boundary cycle. -> that frame shows the previously pending data, pending stays 1, and 3333 appears in the following frame.
- Async reset mid-DRIVE: assert rst_n = 0 while an = D. -> an = F and seg = 7F before the next clock edge. After release, the display stays dark until a new load commits.
